// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and default sizing for the UART transmit arbiter.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} arb_state_t;
  localparam int DEF_NREQ = 4;
  localparam int DEF_START_TIMEOUT = 15;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; search starts one past ptr, lock mask limits eligibility.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [N-1:0] eff;
  assign eff = req & mask;
  always_comb begin
    int k;
    k = 0;
    gnt = '0;
    idx = '0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr) + i) % N;
      if (gnt == '0 && eff[k]) begin
        gnt[k] = 1'b1;
        idx = IW'(k);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte arbiter feeding a UART transmit engine, with packet lock and start timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ          = DEF_NREQ,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RSTb,
  input  logic [NREQ-1:0]   REQ,
  input  logic [8*NREQ-1:0] REQ_DATA,
  input  logic [NREQ-1:0]   REQ_LOCK,
  output logic [NREQ-1:0]   ACK,
  output logic [7:0]        TX_DATA,
  output logic              TX_GO,
  input  logic              TX_DONE,
  output logic [2:0]        OWNER,
  output logic              BUSY,
  output logic              ERR_TIMEOUT
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(START_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(START_TIMEOUT - 1);
  arb_state_t state, next;
  logic [IW-1:0] owner, last_grant, pick_idx;
  logic [NREQ-1:0] owner_oh, pick_gnt, mask;
  logic [CW-1:0] cnt;
  logic lock, tmo;
  // A held lock narrows eligibility to the current owner only.
  assign mask = lock ? owner_oh : '1;
  assign tmo = state == WAIT_START && TX_DONE && cnt == TO_LAST;
  assign BUSY = state != IDLE;
  assign OWNER = 3'(owner);
  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req (REQ),
    .ptr (last_grant),
    .mask(mask),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );
  always_comb begin
    next = state;
    unique case (state)
      IDLE:       next = TX_DONE && |pick_gnt ? LAUNCH : IDLE;
      LAUNCH:     next = WAIT_START;
      WAIT_START: next = !TX_DONE ? WAIT_DONE : tmo ? IDLE : WAIT_START;
      WAIT_DONE:  next = TX_DONE ? IDLE : WAIT_DONE;
      default:    next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state       <= IDLE;
      TX_GO       <= 1'b0;
      ACK         <= '0;
      TX_DATA     <= 8'h00;
      owner       <= '0;
      owner_oh    <= '0;
      last_grant  <= IW'(NREQ - 1);
      lock        <= 1'b0;
      cnt         <= '0;
      ERR_TIMEOUT <= 1'b0;
    end else begin
      state <= next;
      TX_GO <= state == LAUNCH;
      ACK   <= state == LAUNCH ? owner_oh : '0;
      if (state == IDLE && next == LAUNCH) begin
        owner    <= pick_idx;
        owner_oh <= pick_gnt;
      end
      if (state == LAUNCH) begin
        TX_DATA    <= REQ_DATA[{owner, 3'b000} +: 8];
        last_grant <= owner;
        lock       <= |(REQ_LOCK & owner_oh);
        cnt        <= '0;
      end else if (state == WAIT_START) begin
        cnt <= cnt + 1'b1;
      end
      if (tmo) begin
        ERR_TIMEOUT <= 1'b1;
        lock        <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven grant-order checks plus hand sequences for latency, lock, timeout and reset.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rstb;
  logic [3:0] req, req_lock, ack;
  logic [31:0] req_data;
  logic [7:0] tx_data;
  logic tx_go, tx_done, busy, err;
  logic [2:0] owner;
  int n_vec = 0;
  int n_err = 0;
  int eng_mode;
  int flen;
  int ecnt;
  logic eng_done, done_man;

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .CLK(clk), .RSTb(rstb), .REQ(req), .REQ_DATA(req_data), .REQ_LOCK(req_lock),
    .ACK(ack), .TX_DATA(tx_data), .TX_GO(tx_go), .TX_DONE(tx_done),
    .OWNER(owner), .BUSY(busy), .ERR_TIMEOUT(err)
  );

  // Engine model: mode 0 drops done for flen cycles per TX_GO, 1 never starts, 2 follows done_man.
  assign tx_done = eng_mode == 2 ? done_man : eng_done;
  always @(posedge clk) begin
    if (!rstb) begin
      eng_done <= 1'b1;
      ecnt <= 0;
    end else if (eng_mode == 0 && tx_go) begin
      eng_done <= 1'b0;
      ecnt <= flen;
    end else if (!eng_done) begin
      if (ecnt <= 1) eng_done <= 1'b1;
      ecnt <= ecnt - 1;
    end
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    int owner;
  } vec_t;
  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_go(input string name);
    int n = 0;
    while (tx_go !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (tx_go !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no TX_GO within 50 cycles", name);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: BUSY still high after 50 cycles", name);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{4'b1111, 4'b0000, i % 4};
    tbl[8]  = '{4'b0010, 4'b0000, 1};
    tbl[9]  = '{4'b0101, 4'b0100, 2};
    tbl[10] = '{4'b0101, 4'b0100, 2};
    tbl[11] = '{4'b0101, 4'b0000, 2};
    tbl[12] = '{4'b0101, 4'b0000, 0};

    rstb = 1'b0; req = '0; req_lock = '0; req_data = '0;
    eng_mode = 0; flen = 3; done_man = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_go", tx_go, 0);
    check("rst_data", tx_data, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rstb = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 13; v++) begin
      req = tbl[v].req;
      req_lock = tbl[v].lock;
      for (int i = 0; i < 4; i++) req_data[8*i +: 8] = {4'(i), 4'(v)};
      wait_go($sformatf("vec%0d_go", v));
      check($sformatf("vec%0d_owner", v), owner, tbl[v].owner);
      check($sformatf("vec%0d_data", v), tx_data, {4'(tbl[v].owner), 4'(v)});
      check($sformatf("vec%0d_ack", v), ack, 4'b0001 << tbl[v].owner);
      req = req & ~ack;
      wait_idle($sformatf("vec%0d_idle", v));
      check($sformatf("vec%0d_hold", v), tx_data, {4'(tbl[v].owner), 4'(v)});
    end
    req = '0; req_lock = '0;

    // Single requester, 10-cycle frame: TX_GO two cycles after REQ, BUSY drops one cycle after done.
    flen = 10;
    req = 4'b0001; req_data[7:0] = 8'h41;
    @(negedge clk);
    check("lat_go_c1", tx_go, 0);
    check("lat_busy_c1", busy, 1);
    @(negedge clk);
    check("lat_go_c2", tx_go, 1);
    check("lat_data", tx_data, 8'h41);
    check("lat_ack", ack, 4'b0001);
    req = '0;
    @(negedge clk);
    check("go_pulse", tx_go, 0);
    check("ack_pulse", ack, 0);
    for (int n = 0; n < 50 && tx_done !== 1'b1; n++) @(negedge clk);
    check("busy_at_done", busy, 1);
    @(negedge clk);
    check("busy_after_done", busy, 0);

    // Engine never starts: timeout after 15 cycles in WAIT_START.
    eng_mode = 1;
    req = 4'b0100; req_data[23:16] = 8'h5A;
    wait_go("to_go");
    check("to_data", tx_data, 8'h5A);
    check("to_owner", owner, 2);
    req = '0;
    repeat (14) @(negedge clk);
    check("to_err_before", err, 0);
    check("to_busy_before", busy, 1);
    @(negedge clk);
    check("to_err_set", err, 1);
    check("to_busy_idle", busy, 0);
    eng_mode = 0; flen = 3;
    req = 4'b0001;
    wait_go("to_next_go");
    check("to_next_owner", owner, 0);
    req = '0;
    wait_idle("to_next_idle");
    check("to_err_sticky", err, 1);

    // New REQ arriving with done rise in WAIT_DONE is launched from IDLE, not lost.
    done_man = 1'b1; eng_mode = 2;
    req = 4'b0001;
    wait_go("race_first_go");
    req = '0; done_man = 1'b0;
    repeat (3) @(negedge clk);
    done_man = 1'b1; req = 4'b0010; req_data[15:8] = 8'h77;
    @(negedge clk);
    check("race_go_c1", tx_go, 0);
    @(negedge clk);
    check("race_go_c2", tx_go, 0);
    check("race_launch_busy", busy, 1);
    @(negedge clk);
    check("race_go_c3", tx_go, 1);
    check("race_owner", owner, 1);
    check("race_ack", ack, 4'b0010);
    check("race_data", tx_data, 8'h77);
    req = '0; done_man = 1'b0;
    repeat (2) @(negedge clk);
    done_man = 1'b1;
    wait_idle("race_idle");

    // Reset in WAIT_DONE abandons the byte and clears everything.
    eng_mode = 0; flen = 10;
    req = 4'b1000; req_data[31:24] = 8'hC3;
    wait_go("rst2_go");
    req = '0;
    repeat (3) @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    check("rst2_ack", ack, 0);
    check("rst2_go_low", tx_go, 0);
    check("rst2_data", tx_data, 0);
    check("rst2_owner", owner, 0);
    check("rst2_busy", busy, 0);
    check("rst2_err", err, 0);
    rstb = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("rst2_no_ack", ack, 0);
    end
    req = 4'b0011;
    wait_go("rst2_next_go");
    check("rst2_next_owner", owner, 0);
    req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
